// File: rtl/sram_sdp_be.sv
// Simple-dual-port synchronous SRAM with per-lane write enables, hardware clear
// after reset, selectable read-during-write policy and optional output register.
module sram_sdp_be #(
    parameter int width   = 8,
    parameter int depth   = 16,
    parameter int lane_w  = 4,
    parameter int rd_mode = 0,
    parameter int out_reg = 0,
    localparam int LANES  = width / lane_w,
    localparam int AW     = $clog2(depth)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_we,
    input  logic [LANES-1:0]  a_be,
    input  logic [AW-1:0]     a_add,
    input  logic [width-1:0]  a_din,
    input  logic              b_re,
    input  logic [AW-1:0]     b_add,
    output logic [width-1:0]  b_dout,
    output logic              b_valid,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_clr_cnt;
    logic              r_busy;
    logic [width-1:0]  r_mem [depth];
    logic [width-1:0]  r_rd_data;
    logic              r_rd_valid;

    logic              w_a_ok;
    logic              w_b_ok;
    logic              w_idle;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_collide;
    logic [width-1:0]  w_wr_old;
    logic [width-1:0]  w_rd_old;
    logic [width-1:0]  w_merged;
    logic [width-1:0]  w_rd_word;

    function automatic logic [width-1:0] f_merge(
        input logic [width-1:0] old_word,
        input logic [width-1:0] new_word,
        input logic [LANES-1:0] be
    );
        logic [width-1:0] m;
        m = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                m[i*lane_w +: lane_w] = new_word[i*lane_w +: lane_w];
            end
        end
        return m;
    endfunction

    // A power-of-two depth makes every address legal, so no range compare is built.
    generate
        if ((1 << AW) == depth) begin : g_pow2
            assign w_a_ok = 1'b1;
            assign w_b_ok = 1'b1;
        end else begin : g_npow2
            assign w_a_ok = (a_add < AW'(depth));
            assign w_b_ok = (b_add < AW'(depth));
        end
    endgenerate

    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr_en   = w_idle && a_we && w_a_ok;
    assign w_rd_en   = w_idle && b_re;
    assign w_collide = w_wr_en && (a_add == b_add);
    assign w_merged  = f_merge(w_wr_old, a_din, a_be);

    // Old words at both ports; out-of-range reads return zero.
    always_comb begin
        w_wr_old  = '0;
        w_rd_old  = '0;
        w_rd_word = '0;
        if (w_a_ok) begin
            w_wr_old = r_mem[a_add];
        end else begin
            w_wr_old = '0;
        end
        if (w_b_ok) begin
            w_rd_old = r_mem[b_add];
        end else begin
            w_rd_old = '0;
        end
        if ((rd_mode == 1) && w_collide) begin
            w_rd_word = w_merged;
        end else begin
            w_rd_word = w_rd_old;
        end
    end

    // Clear-sequence state machine; busy drops on the edge that clears the last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == AW'(depth - 1)) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + AW'(1);
                    end
                end
                ST_IDLE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: clear writes take priority, lane writes go in as a merged word.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == ST_CLEAR)) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (rst_n && w_wr_en && (a_be != '0)) begin
            r_mem[a_add] <= w_merged;
        end
    end

    // First read stage; data holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_en) begin
            r_rd_data  <= w_rd_word;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    generate
        if (out_reg != 0) begin : g_oreg
            logic [width-1:0] r_out_data;
            logic             r_out_valid;

            // Optional output stage adds one cycle of latency at full throughput.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                end else if (r_rd_valid) begin
                    r_out_data  <= r_rd_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end

            assign b_dout  = r_out_data;
            assign b_valid = r_out_valid;
        end else begin : g_noreg
            assign b_dout  = r_rd_data;
            assign b_valid = r_rd_valid;
        end
    endgenerate

    assign busy = r_busy;

endmodule

// File: tb/tb_sram_sdp_be.sv
// Directed bench: dut0 is read-first with 1-cycle latency, dut1 is write-first
// with the output register; both share the same stimulus.
module tb_sram_sdp_be;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_we;
    logic [1:0] a_be;
    logic [3:0] a_add;
    logic [7:0] a_din;
    logic       b_re;
    logic [3:0] b_add;
    logic [7:0] dout0, dout1;
    logic       valid0, valid1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_sdp_be #(.width(8), .depth(16), .lane_w(4), .rd_mode(0), .out_reg(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .a_we(a_we), .a_be(a_be), .a_add(a_add), .a_din(a_din),
        .b_re(b_re), .b_add(b_add), .b_dout(dout0), .b_valid(valid0), .busy(busy0)
    );

    sram_sdp_be #(.width(8), .depth(16), .lane_w(4), .rd_mode(1), .out_reg(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a_we(a_we), .a_be(a_be), .a_add(a_add), .a_din(a_din),
        .b_re(b_re), .b_add(b_add), .b_dout(dout1), .b_valid(valid1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Busy must stay high for exactly 16 edges after reset release, with no read output.
    task automatic busy_seq(input string tag);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk({tag, "_busy0"}, 32'(busy0), 32'(k < 16));
            chk({tag, "_busy1"}, 32'(busy1), 32'(k < 16));
            chk({tag, "_nv0"}, 32'(valid0), 32'd0);
            chk({tag, "_nv1"}, 32'(valid1), 32'd0);
            if (k == 16) begin
                a_we = 1'b0;
                b_re = 1'b0;
            end
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] data, input logic [1:0] be);
        a_we = 1'b1; a_add = addr; a_din = data; a_be = be;
        tick();
        a_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] addr, input logic [7:0] e0, input logic [7:0] e1);
        b_re = 1'b1; b_add = addr;
        tick();
        b_re = 1'b0;
        chk({tag, "_v0"}, 32'(valid0), 32'd1);
        chk({tag, "_d0"}, 32'(dout0), 32'(e0));
        chk({tag, "_v1early"}, 32'(valid1), 32'd0);
        tick();
        chk({tag, "_v1"}, 32'(valid1), 32'd1);
        chk({tag, "_d1"}, 32'(dout1), 32'(e1));
        chk({tag, "_v0once"}, 32'(valid0), 32'd0);
    endtask

    initial begin
        int cnt0, cnt1, bad;
        rst_n = 1'b0; a_we = 1'b0; a_be = 2'b00; a_add = 4'd0; a_din = 8'h00;
        b_re = 1'b0; b_add = 4'd0;
        tick();
        tick();
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_v0", 32'(valid0), 32'd0);
        chk("rst_v1", 32'(valid1), 32'd0);
        chk("rst_d0", 32'(dout0), 32'd0);
        chk("rst_d1", 32'(dout1), 32'd0);

        // Requests during the clear sequence must be dropped.
        rst_n = 1'b1;
        a_we = 1'b1; a_add = 4'd2; a_din = 8'h77; a_be = 2'b11;
        b_re = 1'b1; b_add = 4'd2;
        busy_seq("clr");

        cnt0 = 0; cnt1 = 0; bad = 0;
        for (int a = 0; a < 16; a++) begin
            b_re = 1'b1; b_add = 4'(a);
            tick();
            cnt0 += int'(valid0); cnt1 += int'(valid1);
            if ((valid0 && dout0 != 8'h00) || (valid1 && dout1 != 8'h00)) bad++;
        end
        b_re = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            cnt0 += int'(valid0); cnt1 += int'(valid1);
            if ((valid0 && dout0 != 8'h00) || (valid1 && dout1 != 8'h00)) bad++;
        end
        chk("sweep_cnt0", 32'(cnt0), 32'd16);
        chk("sweep_cnt1", 32'(cnt1), 32'd16);
        chk("sweep_zero", 32'(bad), 32'd0);

        rd("busywr", 4'd2, 8'h00, 8'h00);

        wr(4'd3, 8'hAB, 2'b11);
        wr(4'd3, 8'h5C, 2'b01);
        rd("lane", 4'd3, 8'hAC, 8'hAC);
        wr(4'd3, 8'hFF, 2'b00);
        rd("be0", 4'd3, 8'hAC, 8'hAC);

        // Same-edge write and read of address 5.
        wr(4'd5, 8'h11, 2'b11);
        a_we = 1'b1; a_add = 4'd5; a_din = 8'hFF; a_be = 2'b10;
        b_re = 1'b1; b_add = 4'd5;
        tick();
        a_we = 1'b0; b_re = 1'b0;
        chk("col_v0", 32'(valid0), 32'd1);
        chk("col_d0", 32'(dout0), 32'h11);
        tick();
        chk("col_v1", 32'(valid1), 32'd1);
        chk("col_d1", 32'(dout1), 32'hF1);
        rd("colnext", 4'd5, 8'hF1, 8'hF1);

        // Back-to-back reads: dut0 on edges N..N+2, dut1 on N+1..N+3.
        wr(4'd0, 8'h10, 2'b11);
        wr(4'd1, 8'h20, 2'b11);
        wr(4'd2, 8'h30, 2'b11);
        b_re = 1'b1; b_add = 4'd0;
        tick();
        chk("lat_n_v0", 32'(valid0), 32'd1);
        chk("lat_n_d0", 32'(dout0), 32'h10);
        chk("lat_n_v1", 32'(valid1), 32'd0);
        b_add = 4'd1;
        tick();
        chk("lat_n1_d0", 32'(dout0), 32'h20);
        chk("lat_n1_v1", 32'(valid1), 32'd1);
        chk("lat_n1_d1", 32'(dout1), 32'h10);
        b_add = 4'd2;
        tick();
        chk("lat_n2_d0", 32'(dout0), 32'h30);
        chk("lat_n2_d1", 32'(dout1), 32'h20);
        b_re = 1'b0;
        tick();
        chk("lat_n3_v0", 32'(valid0), 32'd0);
        chk("lat_n3_hold0", 32'(dout0), 32'h30);
        chk("lat_n3_v1", 32'(valid1), 32'd1);
        chk("lat_n3_d1", 32'(dout1), 32'h30);
        tick();
        chk("lat_n4_v1", 32'(valid1), 32'd0);
        chk("lat_n4_hold1", 32'(dout1), 32'h30);

        // Reset with a read still inside dut1's output pipeline.
        b_re = 1'b1; b_add = 4'd1;
        tick();
        b_re = 1'b0; rst_n = 1'b0;
        tick();
        chk("rrd_v0", 32'(valid0), 32'd0);
        chk("rrd_v1", 32'(valid1), 32'd0);
        chk("rrd_d0", 32'(dout0), 32'd0);
        chk("rrd_d1", 32'(dout1), 32'd0);
        chk("rrd_busy", 32'(busy1), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("rrd_v1_late", 32'(valid1), 32'd0);

        // Reset again part-way through the clear; the full count must restart.
        for (int k = 0; k < 5; k++) tick();
        chk("mid_busy", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        busy_seq("midclr");
        rd("aftclr5", 4'd5, 8'h00, 8'h00);
        rd("aftclr2", 4'd2, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_sdp_be.md
# sram_sdp_be

Parametrised simple-dual-port synchronous SRAM: one write port (A) with per-lane write enables, one read port (B) with registered read data and a valid strobe. Adds a hardware clear sequence after reset, selectable read-during-write behaviour, and an optional output pipeline register. It is the general-purpose buffer RAM for FIFOs and line buffers, replacing the single-port sync-read SRAM where concurrent read and write are needed.

## Interface
- width, 8: data word width in bits; must be a multiple of lane_w.
- depth, 16: number of words; must be at least 2; need not be a power of two.
- lane_w, 4: bits per write lane; lanes = width/lane_w.
- rd_mode, 0: same-address collision policy; 0 = read-first (old data), 1 = write-first (new data).
- out_reg, 0: 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.

- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- a_we  input  1  write request.
- a_be  input  width/lane_w  lane enables; bit i covers data bits [i*lane_w +: lane_w].
- a_add  input  $clog2(depth)  write address.
- a_din  input  width  write data.
- b_re  input  1  read request.
- b_add  input  $clog2(depth)  read address.
- b_dout  output  width  read data; holds the last value between reads (never driven to Z).
- b_valid  output  1  high for exactly one cycle per accepted read, aligned with new b_dout.
- busy  output  1  high while the clear sequence runs; requests are dropped while high.

## Operation
- States: CLEAR, IDLE.
- rst_n low at a posedge: state <= CLEAR, clear counter <= 0, busy <= 1, b_dout <= 0, b_valid <= 0, pipeline registers <= 0.
- CLEAR: each posedge with rst_n high writes all-zeros to mem[counter], counter++. On the edge that writes mem[depth-1], state <= IDLE, busy <= 0.
- In CLEAR, a_we and b_re are ignored (no write, no b_valid); callers must wait for busy low.
- IDLE write: a_we=1 and a_add<depth: for each lane i with a_be[i]=1, mem[a_add] lane i <= a_din lane i; other lanes unchanged. a_be all-zero means no write.
- IDLE read: b_re=1 captures mem[b_add]; b_add>=depth returns all-zeros (still valid). a_add>=depth writes are dropped.
- Collision (a_we, b_re, a_add==b_add, same edge): rd_mode=0 returns the pre-write word; rd_mode=1 returns the merged word (enabled lanes from a_din, other lanes old).
- b_re=0: b_dout holds, b_valid low.

## Timing
- busy is high from reset through exactly depth posedges with rst_n high; first request accepted on the following edge.
- out_reg=0: b_re sampled at edge N -> b_dout/b_valid updated at edge N (visible in cycle N..N+1).
- out_reg=1: same read -> b_dout/b_valid updated at edge N+1; back-to-back reads sustain one per cycle at both settings.
- Write at edge N is visible to a non-colliding read sampled at edge N+1 or later.
- Reset mid-operation (any state, including mid-CLEAR or with reads in the pipeline): in-flight reads are discarded (no b_valid), clear restarts from address 0.
- Collision policy applies equally with out_reg=1; only the latency changes.

## Test plan
- Reset sweep (depth=16): hold rst_n low 2 cycles, release -> busy high exactly 16 edges, then low; read all 16 addresses -> every b_dout=0x00, 16 b_valid pulses.
- Lane write (width=8, lane_w=4): write 0xAB to addr 3 with a_be=2'b11, then 0x5C with a_be=2'b01 -> read addr 3 returns 0xAC.
- Collision: mem[5]=0x11; same edge write 0xFF a_be=2'b10 and read addr 5 -> rd_mode=0 returns 0x11, rd_mode=1 returns 0xF1; next read returns 0xF1 in both.
- Latency: out_reg=1, reads of addrs 0,1,2 on three consecutive edges after writing 0x10,0x20,0x30 -> b_valid high on edges N+1..N+3 with 0x10,0x20,0x30; out_reg=0 -> edges N..N+2.
- Requests during busy: a_we to addr 2 with 0x77 and b_re during CLEAR -> no b_valid; after busy low, read addr 2 returns 0x00.
- Reset mid-sweep and mid-read: drop rst_n during cycle 7 of CLEAR, and separately with out_reg=1 read in flight -> no b_valid, busy stays high for a full 16 edges after release, b_dout=0.
